punc_seq_ctrl: RTL and testbench

Parametrised multicycle control sequencer for the PUnC LC3 core, successor to the fixed-timing controller. Adds a variable-latency memory handshake with a timeout, a debugger-driven single-step mode, and illegal-opcode fault detection. Sits between the PUnC datapath and the top-level wrapper, consuming ir/nzp_true and driving all datapath load/select strobes.

---
 rtl/punc_seq_ctrl_pkg.sv | 56 +++++
 rtl/punc_seq_ctrl_if.sv | 11 +
 rtl/punc_seq_ctrl_mem_wait.sv | 40 ++++
 rtl/punc_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_punc_seq_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/punc_seq_ctrl_pkg.sv
// Shared PUnC definitions: opcodes, controller states and the datapath select
// encodings used by both the sequencer and the datapath.
package punc_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    ST_STEP_WAIT = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC      = 3'd3,
    ST_IND       = 3'd4,
    ST_MEM       = 3'd5,
    ST_HALT      = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [1:0] PC_SEL_BASER = 2'd1;
  localparam logic [1:0] PC_SEL_OFF11 = 2'd2;

  localparam logic [1:0] MEM_ADDR_PC        = 2'd0;
  localparam logic [1:0] MEM_ADDR_PC_OFF9   = 2'd1;
  localparam logic [1:0] MEM_ADDR_BASE_OFF6 = 2'd2;
  localparam logic [1:0] MEM_ADDR_PREV      = 2'd3;

  localparam logic [1:0] RF_DATA_ALU = 2'd0;
  localparam logic [1:0] RF_DATA_MEM = 2'd1;
  localparam logic [1:0] RF_DATA_LEA = 2'd2;
  localparam logic [1:0] RF_DATA_PC  = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_NOT  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/punc_seq_ctrl_if.sv
// Memory handshake between the PUnC sequencer (master) and the memory
// subsystem (slave).
interface punc_seq_ctrl_if;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] mem_addr_sel;
  logic       mem_ready;

  modport master (output mem_rd, output mem_wr, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_rd, input mem_wr, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/punc_seq_ctrl_mem_wait.sv
// Memory wait timer: counts cycles a strobe is held without mem_ready and
// flags the cycle whose wait would reach TIMEOUT_CYC (0 disables).
module punc_mem_wait #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_strobe,
  input  logic i_mem_ready,
  output logic o_timeout
);

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] r_cnt;

      // wait counter, cleared whenever the strobe is idle or memory answers
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!i_strobe || i_mem_ready) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // a ready in the limit cycle completes the access instead of faulting
      assign o_timeout = i_strobe && !i_mem_ready && (r_cnt == LAST);
    end else begin : g_no_timer
      logic w_unused_in;
      assign w_unused_in = i_strobe ^ i_mem_ready ^ clk ^ rst;
      assign o_timeout   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/punc_seq_ctrl.sv
// PUnC multicycle control sequencer with memory timeout, single-step mode and
// illegal-opcode fault. Optional retired-instruction counter: PUNC_PERF_CNT_EN.
module punc_seq_ctrl
  import punc_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] ir,
  input  logic              nzp_true,
  input  logic              step_mode,
  input  logic              step_go,
  punc_seq_ctrl_if.master   mem,
  output logic              ir_ld,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic [1:0]        pc_sel,
  output logic              rf_w_wr,
  output logic [1:0]        rf_w_data_sel,
  output logic              rf_w_addr_sel,
  output logic              prev_ld,
  output logic              nzp_ld,
  output logic [1:0]        alu_sel,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  state_e     r_state;
  state_e     w_next;
  logic       r_rst_hold;
  logic [3:0] w_op;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic [1:0] w_mem_addr_sel;
  logic       w_timeout;
  logic       w_retire;
  logic       w_end_state_step;
  logic       w_unused_ir;

  assign w_op        = ir[WORD_W-1:WORD_W-4];
  assign w_unused_ir = ^ir;

  // r_rst_hold keeps every strobe low for the cycle after a reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_rst_hold <= 1'b0;
    end
  end

  assign w_end_state_step = step_mode;

  // next-state and retirement decode
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    if (r_rst_hold) begin
      w_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_STEP_WAIT: begin
          if (step_go || !step_mode) w_next = ST_FETCH;
          else                       w_next = ST_STEP_WAIT;
        end
        ST_FETCH: begin
          if (mem.mem_ready)  w_next = ST_DECODE;
          else if (w_timeout) w_next = ST_FAULT;
          else                w_next = ST_FETCH;
        end
        ST_DECODE: begin
          case (w_op)
            OP_RTI, OP_RES: w_next = ST_FAULT;
            OP_TRAP: begin
              w_next   = ST_HALT;
              w_retire = 1'b1;
            end
            OP_LDI, OP_STI:                 w_next = ST_IND;
            OP_LD, OP_LDR, OP_ST, OP_STR:   w_next = ST_MEM;
            default:                        w_next = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          w_retire = 1'b1;
          w_next   = w_end_state_step ? ST_STEP_WAIT : ST_FETCH;
        end
        ST_IND: begin
          if (mem.mem_ready)  w_next = ST_MEM;
          else if (w_timeout) w_next = ST_FAULT;
          else                w_next = ST_IND;
        end
        ST_MEM: begin
          if (mem.mem_ready) begin
            w_retire = 1'b1;
            w_next   = w_end_state_step ? ST_STEP_WAIT : ST_FETCH;
          end else if (w_timeout) begin
            w_next = ST_FAULT;
          end else begin
            w_next = ST_MEM;
          end
        end
        ST_HALT:  w_next = ST_HALT;
        ST_FAULT: w_next = ST_FAULT;
        default:  w_next = ST_FAULT;
      endcase
    end
  end

  // datapath strobes; only completion strobes look at mem_ready
  always_comb begin
    ir_ld          = 1'b0;
    pc_ld          = 1'b0;
    pc_inc         = 1'b0;
    pc_sel         = PC_SEL_OFF9;
    w_mem_rd       = 1'b0;
    w_mem_wr       = 1'b0;
    w_mem_addr_sel = MEM_ADDR_PC;
    rf_w_wr        = 1'b0;
    rf_w_data_sel  = RF_DATA_ALU;
    rf_w_addr_sel  = 1'b0;
    prev_ld        = 1'b0;
    nzp_ld         = 1'b0;
    alu_sel        = ALU_ADD;
    halted         = 1'b0;
    fault          = 1'b0;
    if (r_rst_hold) begin
      halted = 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_mem_rd       = 1'b1;
          w_mem_addr_sel = MEM_ADDR_PC;
          ir_ld          = mem.mem_ready;
          pc_inc         = mem.mem_ready;
        end
        ST_EXEC: begin
          case (w_op)
            OP_ADD, OP_AND, OP_NOT: begin
              rf_w_wr = 1'b1;
              nzp_ld  = 1'b1;
              if (w_op == OP_AND)      alu_sel = ALU_AND;
              else if (w_op == OP_NOT) alu_sel = ALU_NOT;
              else                     alu_sel = ALU_ADD;
            end
            OP_LEA: begin
              rf_w_wr       = 1'b1;
              rf_w_data_sel = RF_DATA_LEA;
            end
            OP_BR: begin
              pc_ld  = nzp_true;
              pc_sel = PC_SEL_OFF9;
            end
            OP_JMP: begin
              pc_ld  = 1'b1;
              pc_sel = PC_SEL_BASER;
            end
            OP_JSR: begin
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              rf_w_data_sel = RF_DATA_PC;
              pc_ld         = 1'b1;
              pc_sel        = ir[11] ? PC_SEL_OFF11 : PC_SEL_BASER;
            end
            default: pc_ld = 1'b0;
          endcase
        end
        ST_IND: begin
          w_mem_rd       = 1'b1;
          w_mem_addr_sel = MEM_ADDR_PC_OFF9;
          prev_ld        = mem.mem_ready;
        end
        ST_MEM: begin
          if ((w_op == OP_LDI) || (w_op == OP_STI))     w_mem_addr_sel = MEM_ADDR_PREV;
          else if ((w_op == OP_LDR) || (w_op == OP_STR)) w_mem_addr_sel = MEM_ADDR_BASE_OFF6;
          else                                           w_mem_addr_sel = MEM_ADDR_PC_OFF9;
          if (is_load(w_op)) begin
            w_mem_rd      = 1'b1;
            rf_w_data_sel = RF_DATA_MEM;
            rf_w_wr       = mem.mem_ready;
            nzp_ld        = mem.mem_ready;
          end else begin
            w_mem_wr = 1'b1;
          end
        end
        ST_HALT:  halted = 1'b1;
        ST_FAULT: fault  = 1'b1;
        default:  halted = 1'b0;
      endcase
    end
  end

  assign mem.mem_rd       = w_mem_rd;
  assign mem.mem_wr       = w_mem_wr;
  assign mem.mem_addr_sel = w_mem_addr_sel;

  punc_mem_wait #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .i_strobe    (w_mem_rd | w_mem_wr),
    .i_mem_ready (mem.mem_ready),
    .o_timeout   (w_timeout)
  );

`ifdef PUNC_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // retired-instruction counter, wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign instr_count = r_instr_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign instr_count     = '0;
`endif

endmodule

// File: tb/tb_punc_seq_ctrl.sv
// Directed self-checking bench for punc_seq_ctrl (TIMEOUT_CYC=4).
module tb_punc_seq_ctrl;
  import punc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        nzp_true, step_mode, step_go;
  logic        ir_ld, pc_ld, pc_inc, rf_w_wr, rf_w_addr_sel, prev_ld, nzp_ld, halted, fault;
  logic [1:0]  pc_sel, rf_w_data_sel, alu_sel;
  logic [31:0] instr_count;
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef PUNC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  punc_seq_ctrl_if u_if ();

  punc_seq_ctrl #(.WORD_W(16), .TIMEOUT_CYC(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true), .step_mode(step_mode),
    .step_go(step_go), .mem(u_if), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_sel(pc_sel), .rf_w_wr(rf_w_wr), .rf_w_data_sel(rf_w_data_sel),
    .rf_w_addr_sel(rf_w_addr_sel), .prev_ld(prev_ld), .nzp_ld(nzp_ld),
    .alu_sel(alu_sel), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  // Called at a negedge in FETCH; returns at the DECODE negedge.
  task automatic fetch(input logic [15:0] instr, input int lat);
    ir = instr;
    for (int i = 0; i < lat; i++) begin
      u_if.mem_ready = 1'b0;
      #1;
      check_eq("fetch_wait", 32'({ir_ld, pc_inc, u_if.mem_rd}), 32'h1);
      @(negedge clk);
    end
    u_if.mem_ready = 1'b1;
    #1;
    check_eq("fetch_done", 32'({ir_ld, pc_inc, u_if.mem_rd, u_if.mem_addr_sel}), 32'h1C);
    @(negedge clk);
    u_if.mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ir = 16'h0000; nzp_true = 1'b0; step_mode = 1'b0; step_go = 1'b0;
    u_if.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", 32'({u_if.mem_rd, u_if.mem_wr, ir_ld, pc_ld, rf_w_wr, halted, fault}), 32'h0);
    check_eq("rst_count", instr_count, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ADD R1,R1,#1 with memory 3 cycles late
    fetch(16'h1261, 3);
    #1 check_eq("add_decode", 32'({u_if.mem_rd, ir_ld, rf_w_wr, pc_ld}), 32'h0);
    @(negedge clk);
    #1 check_eq("add_exec", 32'({rf_w_wr, nzp_ld, alu_sel, rf_w_data_sel, pc_ld}), 32'h60);
    @(negedge clk);
    check_eq("add_count", instr_count, exp_cnt(1));

    // LDI: FETCH, DECODE, IND, MEM
    fetch(16'hA005, 0);
    #1 check_eq("ldi_decode", 32'({u_if.mem_rd, u_if.mem_wr}), 32'h0);
    @(negedge clk);
    u_if.mem_ready = 1'b1;
    #1 check_eq("ldi_ind", 32'({u_if.mem_rd, u_if.mem_addr_sel, prev_ld, rf_w_wr}), 32'h16);
    @(negedge clk);
    u_if.mem_ready = 1'b0;
    #1 check_eq("ldi_mem", 32'({u_if.mem_rd, u_if.mem_wr, u_if.mem_addr_sel, rf_w_data_sel, rf_w_wr}), 32'h5A);
    u_if.mem_ready = 1'b1;
    #1 check_eq("ldi_done", 32'({rf_w_wr, nzp_ld, rf_w_addr_sel, prev_ld}), 32'hC);
    @(negedge clk);
    u_if.mem_ready = 1'b0;
    #1 check_eq("ldi_refetch", 32'({u_if.mem_rd, u_if.mem_addr_sel}), 32'h4);
    check_eq("ldi_count", instr_count, exp_cnt(2));

    // BRz not taken then taken
    nzp_true = 1'b0;
    fetch(16'h0403, 0);
    @(negedge clk);
    #1 check_eq("br_not_taken", 32'({pc_ld, rf_w_wr}), 32'h0);
    @(negedge clk);
    nzp_true = 1'b1;
    fetch(16'h0403, 0);
    @(negedge clk);
    #1 check_eq("br_taken", 32'({pc_ld, pc_sel}), 32'h4);
    @(negedge clk);
    nzp_true = 1'b0;

    // JSR with ir[11]=1
    fetch(16'h4800, 0);
    @(negedge clk);
    #1 check_eq("jsr_exec", 32'({rf_w_wr, rf_w_addr_sel, rf_w_data_sel, pc_ld, pc_sel, nzp_ld}), 32'hFC);
    @(negedge clk);

    // ST with one wait cycle
    fetch(16'h3005, 0);
    @(negedge clk);
    #1 check_eq("st_mem", 32'({u_if.mem_wr, u_if.mem_rd, u_if.mem_addr_sel}), 32'h9);
    @(negedge clk);
    u_if.mem_ready = 1'b1;
    #1 check_eq("st_done", 32'({rf_w_wr, nzp_ld, u_if.mem_wr}), 32'h1);
    @(negedge clk);
    u_if.mem_ready = 1'b0;
    check_eq("st_count", instr_count, exp_cnt(6));

    // single-step: three NOTs
    step_mode = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      fetch(16'h927F, 0);
      @(negedge clk);
      #1 check_eq("not_exec", 32'({rf_w_wr, nzp_ld, alu_sel}), 32'hE);
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        #1 check_eq("step_idle", 32'({u_if.mem_rd, ir_ld, rf_w_wr}), 32'h0);
        @(negedge clk);
      end
      check_eq("step_count", instr_count, exp_cnt(6 + k));
      if (k < 3) step_go = 1'b1;
      else       step_mode = 1'b0;
      @(negedge clk);
      step_go = 1'b0;
      #1 check_eq("step_release", 32'({u_if.mem_rd, u_if.mem_addr_sel}), 32'h4);
    end

    // reserved opcode faults after DECODE
    fetch(16'hD000, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      u_if.mem_ready = i[0];
      #1 check_eq("fault_sticky", 32'({fault, u_if.mem_rd, ir_ld}), 32'h4);
      @(negedge clk);
    end
    u_if.mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("fault_rst", 32'({fault, u_if.mem_rd}), 32'h0);
    check_eq("fault_rst_count", instr_count, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // timeout: ready held low in FETCH
    for (int i = 1; i <= 4; i++) begin
      #1 check_eq("to_wait", 32'({u_if.mem_rd, fault}), 32'h2);
      @(negedge clk);
    end
    check_eq("to_fault", 32'({fault, u_if.mem_rd}), 32'h2);
    @(negedge clk);
    check_eq("to_strobe_off", 32'({fault, u_if.mem_rd}), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("to_rst_fetch", 32'({fault, u_if.mem_rd}), 32'h1);

    // TRAP halts for good
    fetch(16'hF025, 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      u_if.mem_ready = i[0];
      #1 check_eq("halt_quiet", 32'({halted, fault, u_if.mem_rd, u_if.mem_wr, ir_ld, pc_ld,
                                      pc_inc, rf_w_wr, nzp_ld, prev_ld}), 32'h200);
      @(negedge clk);
    end
    u_if.mem_ready = 1'b0;
    check_eq("halt_count", instr_count, exp_cnt(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
